// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive constants.
// Byte width, oversample factor and default divider width.
package uart_rx_ctrl_pkg;
  localparam int BYTE_W    = 8;
  localparam int OVS       = 8;
  localparam int DIV_W_DEF = 16;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Head word appears on dout while not empty; zero otherwise.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop on full frees the slot for a same-cycle push
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for a uart_rx engine: sample clock,
// receiver reset, byte capture FIFO, overrun and idle.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int IDLE_TICKS = 160,
  parameter int LW         = $clog2(DEPTH) + 1
) (
  input  logic              ref_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              samp_clk,
  output logic              rx_reset,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              m_valid,
  output logic [BYTE_W-1:0] m_data,
  input  logic              m_ready,
  output logic [LW-1:0]     level,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              idle
);
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TICKS);

  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_max;
  logic              div_tc;
  logic              samp_rise;
  logic              rdy_s1;
  logic              rdy_s2;
  logic              rdy_s3;
  logic [BYTE_W-1:0] data_q;
  logic              push;
  logic              full;
  logic              empty;
  logic              drop;
  logic [IW-1:0]     idle_cnt;
  logic              armed;

  assign div_max   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign div_tc    = (div_cnt >= div_max - 1'b1);
  assign samp_rise = enable && div_tc && !samp_clk;

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      samp_clk <= 1'b0;
      rx_reset <= 1'b1;
    end else begin
      rx_reset <= ~enable;
      if (!enable) begin
        div_cnt  <= '0;
        samp_clk <= 1'b0;
      end else if (div_tc) begin
        div_cnt  <= '0;
        samp_clk <= ~samp_clk;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_s1 <= 1'b0;
      rdy_s2 <= 1'b0;
      rdy_s3 <= 1'b0;
      data_q <= '0;
    end else begin
      rdy_s1 <= rx_ready;
      rdy_s2 <= rdy_s1;
      rdy_s3 <= rdy_s2;
      data_q <= rx_data;
    end
  end

  assign push    = rdy_s2 && !rdy_s3;
  assign m_valid = !empty;
  assign drop    = push && full && !m_ready;

  sync_fifo #(
    .W     (BYTE_W),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (ref_clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (data_q),
    .pop     (m_ready),
    .dout    (m_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n)     overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

  // idle fires once per burst: armed by a push, spent by the pulse
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      armed    <= 1'b0;
      idle     <= 1'b0;
    end else begin
      idle <= 1'b0;
      if (!enable) begin
        idle_cnt <= '0;
        armed    <= 1'b0;
      end else if (push) begin
        idle_cnt <= '0;
        armed    <= 1'b1;
      end else if (samp_rise && idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
        if (armed && idle_cnt == IDLE_MAX - 1'b1) begin
          idle  <= 1'b1;
          armed <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: vector table for the
// FIFO path plus sequences for timing corner cases.
module tb_uart_rx_ctrl;
  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] cfg_div;
  logic        samp_clk;
  logic        rx_reset;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [2:0]  level;
  logic        overrun;
  logic        ovr_clr;
  logic        idle;

  int errors = 0;
  int checks = 0;

  uart_rx_ctrl #(
    .DEPTH      (4),
    .DIV_W      (16),
    .IDLE_TICKS (160)
  ) dut (
    .ref_clk  (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .cfg_div  (cfg_div),
    .samp_clk (samp_clk),
    .rx_reset (rx_reset),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .level    (level),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       send;
    logic [7:0] d;
    logic       mr;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] el;
    logic       eo;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(
    input logic s, input logic [7:0] d,
    input logic mr, input logic c,
    input logic ev, input logic [7:0] ed,
    input logic [2:0] el, input logic eo);
    vec_t v;
    v.send = s;  v.d  = d;  v.mr = mr; v.clr = c;
    v.ev   = ev; v.ed = ed; v.el = el; v.eo  = eo;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    rx_data  = v.d;
    rx_ready = v.send;
    m_ready  = v.mr;
    ovr_clr  = v.clr;
    @(negedge clk);
    m_ready = 1'b0;
    ovr_clr = 1'b0;
    if (v.send) begin
      repeat (4) @(negedge clk);
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  // pp/cc land on exactly the edge where the push happens
  task automatic send_sync(input logic [7:0] d,
                           input logic pp,
                           input logic cc);
    @(negedge clk);
    rx_data  = d;
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_ready = pp;
    ovr_clr = cc;
    @(negedge clk);
    m_ready = 1'b0;
    ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_chk(input logic [7:0] e);
    chk("pop_valid", 32'(m_valid), 32'd1);
    chk("pop_data", 32'(m_data), 32'(e));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic measure(output int hi, output int lo);
    int n;
    n = 0;
    while (samp_clk !== 1'b0 && n < 50) begin
      @(negedge clk); n++;
    end
    n = 0;
    while (samp_clk !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    hi = 0;
    while (samp_clk === 1'b1 && hi < 50) begin
      @(negedge clk); hi++;
    end
    lo = 0;
    while (samp_clk === 1'b0 && lo < 50) begin
      @(negedge clk); lo++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_samp"},  32'(samp_clk), 32'd0);
    chk({tag, "_rxrst"}, 32'(rx_reset), 32'd1);
    chk({tag, "_valid"}, 32'(m_valid),  32'd0);
    chk({tag, "_data"},  32'(m_data),   32'd0);
    chk({tag, "_level"}, 32'(level),    32'd0);
    chk({tag, "_ovr"},   32'(overrun),  32'd0);
    chk({tag, "_idle"},  32'(idle),     32'd0);
  endtask

  initial begin
    int hi;
    int lo;
    int pulses;
    int at;

    tv[0]  = mk(1'b1, 8'hAC, 1'b0, 1'b0, 1'b1, 8'hAC, 3'd1, 1'b0);
    tv[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    tv[2]  = mk(1'b1, 8'h93, 1'b0, 1'b0, 1'b1, 8'h93, 3'd1, 1'b0);
    tv[3]  = mk(1'b1, 8'h4D, 1'b0, 1'b0, 1'b1, 8'h93, 3'd2, 1'b0);
    tv[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h4D, 3'd1, 1'b0);
    tv[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    tv[6]  = mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0);
    tv[7]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0);
    tv[8]  = mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0);
    tv[9]  = mk(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0);
    tv[10] = mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1);
    tv[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b0);
    tv[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 3'd3, 1'b0);
    tv[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 3'd2, 1'b0);
    tv[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3'd1, 1'b0);
    tv[15] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);

    reset_n  = 1'b0;
    enable   = 1'b0;
    cfg_div  = 16'd1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    m_ready  = 1'b0;
    ovr_clr  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("en_rxrst", 32'(rx_reset), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_vec(tv[i]);
      chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d_data", i), 32'(m_data), 32'(tv[i].ed));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tv[i].el));
      chk($sformatf("v%0d_ovr", i), 32'(overrun), 32'(tv[i].eo));
    end

    // clear colliding with a drop: set wins
    send_sync(8'h11, 1'b0, 1'b0);
    send_sync(8'h22, 1'b0, 1'b0);
    send_sync(8'h33, 1'b0, 1'b0);
    send_sync(8'h44, 1'b0, 1'b0);
    send_sync(8'h55, 1'b0, 1'b1);
    chk("clr_drop_ovr", 32'(overrun), 32'd1);
    chk("clr_drop_lvl", 32'(level), 32'd4);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);
    pop_chk(8'h11);
    pop_chk(8'h22);
    pop_chk(8'h33);
    pop_chk(8'h44);
    chk("drain1_lvl", 32'(level), 32'd0);

    // push and pop together on full
    send_sync(8'h61, 1'b0, 1'b0);
    send_sync(8'h62, 1'b0, 1'b0);
    send_sync(8'h63, 1'b0, 1'b0);
    send_sync(8'h64, 1'b0, 1'b0);
    send_sync(8'h65, 1'b1, 1'b0);
    chk("pp_full_lvl", 32'(level), 32'd4);
    chk("pp_full_ovr", 32'(overrun), 32'd0);
    pop_chk(8'h62);
    pop_chk(8'h63);
    pop_chk(8'h64);
    pop_chk(8'h65);
    chk("drain2_valid", 32'(m_valid), 32'd0);

    cfg_div = 16'd3;
    repeat (10) @(negedge clk);
    measure(hi, lo);
    chk("div3_hi", 32'(hi), 32'd3);
    chk("div3_lo", 32'(lo), 32'd3);
    cfg_div = 16'd0;
    repeat (10) @(negedge clk);
    measure(hi, lo);
    chk("div0_hi", 32'(hi), 32'd1);
    chk("div0_lo", 32'(lo), 32'd1);
    cfg_div = 16'd1;
    repeat (4) @(negedge clk);

    // disable keeps FIFO contents
    send_sync(8'hC7, 1'b0, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_samp", 32'(samp_clk), 32'd0);
    chk("dis_rxrst", 32'(rx_reset), 32'd1);
    repeat (3) @(negedge clk);
    chk("dis_samp2", 32'(samp_clk), 32'd0);
    chk("dis_level", 32'(level), 32'd1);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_rxrst", 32'(rx_reset), 32'd0);
    pop_chk(8'hC7);

    pulses = 0;
    at = -1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rx_data  = 8'h5A;
        rx_ready = 1'b1;
      end
      if (i == 6) rx_ready = 1'b0;
      if (idle === 1'b1) begin
        pulses++;
        at = i;
      end
    end
    chk("idle_pulses", 32'(pulses), 32'd1);
    chk("idle_time", 32'(at >= 310 && at <= 340), 32'd1);
    pop_chk(8'h5A);

    // reset mid-frame
    send_sync(8'h77, 1'b0, 1'b0);
    @(negedge clk);
    rx_data  = 8'h88;
    rx_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    rx_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_lvl", 32'(level), 32'd0);
    chk("post_valid", 32'(m_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
